// File: rtl/pcie_mrd_axi_master.sv
// AXI4 read master: turns PCIe memory-read requests into INCR bursts and
// forwards the returned beats, tagged and error-marked, through a small completion FIFO.
module pcie_mrd_axi_master #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_addr,
  input  logic [11:0]      req_len,
  input  logic [TAG_W-1:0] req_tag,
  output logic             axi_arvalid,
  output logic [63:0]      axi_araddr,
  output logic [11:0]      axi_arlen,
  output logic [2:0]       axi_arsize,
  output logic [1:0]       axi_arburst,
  input  logic             axi_arready,
  input  logic             axi_rvalid,
  input  logic [255:0]     axi_rdata,
  input  logic [1:0]       axi_rresp,
  input  logic             axi_rlast,
  output logic             axi_rready,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [255:0]     cpl_data,
  output logic [TAG_W-1:0] cpl_tag,
  output logic             cpl_last,
  output logic             cpl_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FLUSH} state_e;

  typedef struct packed {
    logic [255:0]     data;
    logic [TAG_W-1:0] tag;
    logic             last;
    logic             err;
  } entry_t;

  state_e           state_q, state_d;
  logic             arvalid_q, arvalid_d;
  logic [63:0]      araddr_q, araddr_d;
  logic [11:0]      arlen_q, arlen_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [12:0]      beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t mem_q [DEPTH];
  entry_t push_entry;
  entry_t head;
  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   r_hs;
  logic   at_end;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // rready depends only on registered state, never on cpl_ready.
  assign axi_rready = ((state_q == S_DATA) && !fifo_full) || (state_q == S_FLUSH);
  assign req_ready  = (state_q == S_IDLE);
  assign r_hs       = axi_rvalid && axi_rready;
  assign at_end     = (beat_cnt_q == {1'b0, arlen_q});

  assign cpl_valid  = !fifo_empty;
  assign pop        = cpl_valid && cpl_ready;
  assign head       = mem_q[rd_ptr_q];
  assign cpl_data   = cpl_valid ? head.data : '0;
  assign cpl_tag    = cpl_valid ? head.tag  : '0;
  assign cpl_last   = cpl_valid && head.last;
  assign cpl_err    = cpl_valid && head.err;

  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = 3'b101;
  assign axi_arburst = 2'b01;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d         = state_q;
    arvalid_d       = arvalid_q;
    araddr_d        = araddr_q;
    arlen_d         = arlen_q;
    tag_d           = tag_q;
    beat_cnt_d      = beat_cnt_q;
    push            = 1'b0;
    push_entry.data = axi_rdata;
    push_entry.tag  = tag_q;
    push_entry.last = 1'b0;
    push_entry.err  = (axi_rresp != 2'b00);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          araddr_d  = req_addr;
          arlen_d   = req_len;
          tag_d     = req_tag;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          push = 1'b1;
          if (axi_rlast) begin
            // Normal end when the count agrees; otherwise the slave ended early.
            push_entry.last = 1'b1;
            push_entry.err  = push_entry.err || !at_end;
            state_d         = S_IDLE;
          end else if (at_end) begin
            // Slave overran the requested length: close the completion, drain the rest.
            push_entry.last = 1'b1;
            push_entry.err  = 1'b1;
            state_d         = S_FLUSH;
          end else begin
            beat_cnt_d = beat_cnt_q + 13'd1;
          end
        end
      end
      S_FLUSH: begin
        if (r_hs && axi_rlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      tag_q      <= '0;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      tag_q      <= tag_d;
      beat_cnt_q <= beat_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the empty count masks stale entries and outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_pcie_mrd_axi_master.sv
// Self-checking bench: scripted AXI read slave, completion monitor, and a
// burst-level reference model that derives expected completions from each request.
module tb_pcie_mrd_axi_master;

  localparam int TAG_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_addr;
  logic [11:0]      req_len;
  logic [TAG_W-1:0] req_tag;
  logic             axi_arvalid;
  logic [63:0]      axi_araddr;
  logic [11:0]      axi_arlen;
  logic [2:0]       axi_arsize;
  logic [1:0]       axi_arburst;
  logic             axi_arready;
  logic             axi_rvalid;
  logic [255:0]     axi_rdata;
  logic [1:0]       axi_rresp;
  logic             axi_rlast;
  logic             axi_rready;
  logic             cpl_valid;
  logic             cpl_ready;
  logic [255:0]     cpl_data;
  logic [TAG_W-1:0] cpl_tag;
  logic             cpl_last;
  logic             cpl_err;

  always #5 clk = ~clk;

  pcie_mrd_axi_master #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_tag(req_tag),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
    .cpl_tag(cpl_tag), .cpl_last(cpl_last), .cpl_err(cpl_err)
  );

  typedef struct {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } rbeat_t;

  typedef struct packed {
    logic [255:0]     data;
    logic [TAG_W-1:0] tag;
    logic             last;
    logic             err;
  } cpl_t;

  // Written by the tests only.
  rbeat_t r_script[$];
  cpl_t   exp_q[$];
  int     r_base   = 0;
  int     ar_stall = 0;
  int     cpl_mode = 1;   // 0: hold low, 1: hold high, 2: random

  // Written by the slave/monitor process only.
  cpl_t   got_q[$];
  int     got_cyc[$];
  int     r_idx = 0;
  int     ar_hs_cnt = 0;
  int     last_r_cyc = 0;
  int     cyc = 0;

  int passed = 0;
  int total  = 0;

  // AXI read slave and completion monitor: sample at negedge, drive just after posedge.
  initial begin
    bit r_seen;
    bit ar_seen;
    bit ar_v;
    int ar_wait;
    ar_wait     = 0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = '0;
    axi_rlast   = 1'b0;
    cpl_ready   = 1'b0;
    forever begin
      @(negedge clk);
      r_seen  = rst_n && axi_rvalid && axi_rready;
      ar_seen = rst_n && axi_arvalid && axi_arready;
      ar_v    = axi_arvalid;
      if (r_seen) last_r_cyc = cyc;
      if (rst_n && cpl_valid && cpl_ready) begin
        cpl_t c;
        c.data = cpl_data;
        c.tag  = cpl_tag;
        c.last = cpl_last;
        c.err  = cpl_err;
        got_q.push_back(c);
        got_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (r_seen) r_idx++;
      if (r_idx < r_base) r_idx = r_base;
      if (ar_seen) ar_hs_cnt++;
      ar_wait     = ar_v ? ar_wait + 1 : 0;
      axi_arready = (ar_wait >= ar_stall);
      if (r_idx < r_script.size()) begin
        axi_rvalid = 1'b1;
        axi_rdata  = r_script[r_idx].data;
        axi_rresp  = r_script[r_idx].resp;
        axi_rlast  = r_script[r_idx].last;
      end else begin
        axi_rvalid = 1'b0;
        axi_rdata  = '0;
        axi_rresp  = '0;
        axi_rlast  = 1'b0;
      end
      case (cpl_mode)
        0:       cpl_ready = 1'b0;
        1:       cpl_ready = 1'b1;
        default: cpl_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: beat i of a burst with length field len is final when the
  // slave marks it last or when i == len; it is errored on a bad response or
  // whenever rlast disagrees with i == len. Beats after the final one are dropped.
  task automatic model(input logic [TAG_W-1:0] tag, input int len, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      cpl_t c;
      c.data = r_script[first + i].data;
      c.tag  = tag;
      c.last = r_script[first + i].last || (i == len);
      c.err  = (r_script[first + i].resp != 2'b00) || (r_script[first + i].last != (i == len));
      exp_q.push_back(c);
      if (c.last) break;
    end
  endtask

  task automatic add_beats(input int n, input int last_at, input int err_at);
    for (int i = 0; i < n; i++) begin
      rbeat_t b;
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
      b.resp = (i == err_at) ? 2'b10 : 2'b00;
      b.last = (i == last_at);
      r_script.push_back(b);
    end
  endtask

  task automatic issue_req(input logic [63:0] addr, input logic [11:0] len, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    req_tag   = tag;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL req_accept: req_ready=0 for 300 cycles, required 1 (tag %h)", tag);
    end
  endtask

  task automatic wait_cpl(input int target, input int limit);
    int n;
    n = 0;
    while (got_q.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < target) begin
      total++;
      $display("FAIL cpl_timeout: got %0d beats, required %0d", got_q.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({axi_arvalid, axi_rready, cpl_valid, cpl_last, cpl_err, axi_arsize, axi_arburst} !== 10'b00000_101_01)
      $display("FAIL reset_ctrl: got %b required %b",
               {axi_arvalid, axi_rready, cpl_valid, cpl_last, cpl_err, axi_arsize, axi_arburst}, 10'b00000_101_01);
    else passed++;
    total++;
    if ({axi_araddr, axi_arlen} !== 76'd0) $display("FAIL reset_ar: got %h required 0", {axi_araddr, axi_arlen});
    else passed++;
    total++;
    if ({cpl_data, cpl_tag} !== '0) $display("FAIL reset_cpl: got %h required 0", {cpl_data, cpl_tag});
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready);
    else passed++;
  endtask

  task automatic test_single_beat();
    rbeat_t b;
    int gb, eb, first;
    cpl_mode = 1;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size();
    b.data = {8{32'hA5A5_A5A5}};
    b.resp = 2'b00;
    b.last = 1'b1;
    r_script.push_back(b);
    model(8'h11, 0, first, 1);
    issue_req(64'h40, 12'd0, 8'h11);
    @(negedge clk);
    total++;
    if ({axi_arvalid, axi_araddr, axi_arlen} !== {1'b1, 64'h40, 12'd0})
      $display("FAIL single_ar: got v=%b a=%h l=%0d required v=1 a=40 l=0", axi_arvalid, axi_araddr, axi_arlen);
    else passed++;
    wait_cpl(gb + 1, 50);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + 1) $display("FAIL single_count: got %0d beats required 1", got_q.size() - gb);
    else passed++;
    if (got_q.size() > gb) begin
      total++;
      if (got_q[gb] !== exp_q[eb]) $display("FAIL single_beat: got %h required %h", got_q[gb], exp_q[eb]);
      else passed++;
      total++;
      if (got_cyc[gb] - last_r_cyc != 1)
        $display("FAIL single_latency: got %0d cycles required 1", got_cyc[gb] - last_r_cyc);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int gb, eb, first, r0, n;
    cpl_mode = 0;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size(); r0 = r_idx;
    add_beats(8, 7, -1);
    model(8'h22, 7, first, 8);
    issue_req(64'h1000, 12'd7, 8'h22);
    repeat (20) @(negedge clk);
    total++;
    if (r_idx - r0 != DEPTH) $display("FAIL bp_r_handshakes: got %0d required %0d", r_idx - r0, DEPTH);
    else passed++;
    total++;
    if (axi_rready !== 1'b0) $display("FAIL bp_rready: got %b required 0", axi_rready);
    else passed++;
    total++;
    if (got_q.size() != gb) $display("FAIL bp_no_cpl: got %0d beats required 0", got_q.size() - gb);
    else passed++;
    cpl_mode = 1;
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL bp_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL bp_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_ar_stall();
    int gb, eb, first, a0, hi, n;
    bit stable, seen_low;
    cpl_mode = 1;
    ar_stall = 3;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size(); a0 = ar_hs_cnt;
    add_beats(3, 2, -1);
    model(8'h33, 2, first, 3);
    issue_req(64'hDEAD_BEE0, 12'd2, 8'h33);
    hi = 0; stable = 1'b1; seen_low = 1'b0;
    for (int c = 0; c < 20 && !seen_low; c++) begin
      @(negedge clk);
      if (axi_arvalid) begin
        hi++;
        if (axi_araddr !== 64'hDEAD_BEE0 || axi_arlen !== 12'd2) stable = 1'b0;
      end else if (hi > 0) seen_low = 1'b1;
    end
    ar_stall = 0;
    total++;
    if (!stable) $display("FAIL ar_stall_stable: got changing araddr/arlen required stable");
    else passed++;
    total++;
    if (hi != 4) $display("FAIL ar_stall_valid_cycles: got %0d required 4", hi);
    else passed++;
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (3) @(negedge clk);
    total++;
    if (ar_hs_cnt - a0 != 1) $display("FAIL ar_stall_handshakes: got %0d required 1", ar_hs_cnt - a0);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL ar_stall_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_rresp_err();
    int gb, eb, first, n;
    cpl_mode = 2;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size();
    add_beats(4, 3, 1);
    model(8'h44, 3, first, 4);
    issue_req(64'h2000, 12'd3, 8'h44);
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL rresp_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL rresp_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_early_last();
    int gb, eb, first, n;
    bit found;
    cpl_mode = 1;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size();
    add_beats(2, 1, -1);
    model(8'h55, 3, first, 2);
    issue_req(64'h3000, 12'd3, 8'h55);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = axi_rvalid && axi_rready && axi_rlast;
    end
    @(negedge clk);
    total++;
    if (!found || req_ready !== 1'b1) $display("FAIL early_req_ready: got %b (last seen %b) required 1", req_ready, found);
    else passed++;
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL early_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL early_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_missing_last();
    int gb, eb, first, r0, n;
    cpl_mode = 1;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size(); r0 = r_idx;
    add_beats(4, 3, -1);
    model(8'h66, 1, first, 4);
    issue_req(64'h4000, 12'd1, 8'h66);
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (10) @(negedge clk);
    total++;
    if (r_idx - r0 != 4) $display("FAIL missing_drained: got %0d R beats accepted required 4", r_idx - r0);
    else passed++;
    total++;
    if (got_q.size() != gb + n) $display("FAIL missing_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    total++;
    if (req_ready !== 1'b1) $display("FAIL missing_idle: got req_ready=%b required 1", req_ready);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL missing_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_throughput();
    int gb, eb, first, n;
    cpl_mode = 1;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size();
    add_beats(16, 15, -1);
    model(8'h77, 15, first, 16);
    issue_req(64'h5000, 12'd15, 8'h77);
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 200);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL tput_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    if (got_q.size() >= gb + n) begin
      total++;
      if (got_cyc[gb + n - 1] - got_cyc[gb] != n - 1)
        $display("FAIL tput_cycles: got %0d cycles for %0d beats required %0d", got_cyc[gb + n - 1] - got_cyc[gb], n, n - 1);
      else passed++;
    end
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL tput_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int r0, gb, eb, first, n, c;
    cpl_mode = 1;
    r0 = r_idx;
    add_beats(8, 7, -1);
    issue_req(64'h6000, 12'd7, 8'h88);
    c = 0;
    while (r_idx - r0 < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1;
    rst_n  = 1'b0;
    r_base = r_script.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({cpl_valid, axi_arvalid, axi_rready, req_ready} !== 4'b0001)
      $display("FAIL midreset_state: got cv/arv/rr/reqr=%b required 0001", {cpl_valid, axi_arvalid, axi_rready, req_ready});
    else passed++;
    gb = got_q.size(); eb = exp_q.size(); first = r_script.size();
    add_beats(4, 3, -1);
    model(8'h99, 3, first, 4);
    issue_req(64'h7000, 12'd3, 8'h99);
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 100);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL midreset_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL midreset_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int gb, eb, n;
    cpl_mode = 2;
    gb = got_q.size(); eb = exp_q.size();
    for (int k = 0; k < 12; k++) begin
      int len, nb, last_at, err_at, mode, first;
      logic [TAG_W-1:0] tag;
      len    = $urandom_range(0, 15);
      tag    = TAG_W'($urandom);
      mode   = $urandom_range(0, 9);
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      if (mode < 6) begin
        nb = len + 1; last_at = len;
      end else if (mode < 8 && len > 0) begin
        last_at = $urandom_range(0, len - 1); nb = last_at + 1;
      end else begin
        nb = len + 1 + int'($urandom_range(1, 3)); last_at = nb - 1;
      end
      first = r_script.size();
      add_beats(nb, last_at, err_at);
      model(tag, len, first, nb);
      issue_req({32'h0, $urandom} & ~64'h1F, 12'(len), tag);
    end
    n = exp_q.size() - eb;
    wait_cpl(gb + n, 3000);
    repeat (10) @(negedge clk);
    total++;
    if (got_q.size() != gb + n) $display("FAIL b2b_count: got %0d beats required %0d", got_q.size() - gb, n);
    else passed++;
    total++;
    if (r_idx != r_script.size() || req_ready !== 1'b1)
      $display("FAIL b2b_drained: got %0d/%0d R beats, req_ready=%b required all beats and 1", r_idx, r_script.size(), req_ready);
    else passed++;
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[gb + i], exp_q[eb + i]);
      else passed++;
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_tag   = '0;
    rst_n     = 1'b0;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_ar_stall();
    test_rresp_err();
    test_early_last();
    test_missing_last();
    test_throughput();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
